// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment driver: NUM_DIGITS BCD digits share one segment bus,
// with registered loading, leading-zero blanking, blink and a frame-wrap pulse.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 3,
  parameter int SCAN_DIV   = 4,
  parameter int BLINK_DIV  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    load,
  input  logic                    blank_lz,
  input  logic                    blink_en,
  output logic [0:6]              segs,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame
);

  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);
  localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

  logic [4*NUM_DIGITS-1:0] disp;
  logic [DW-1:0]           div_cnt;
  logic [IW-1:0]           idx;
  logic [BW-1:0]           blink_cnt;
  logic                    phase;
  logic                    wrap_d;

  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   upper_zero;
  logic [0:6]              next_segs;
  logic [NUM_DIGITS-1:0]   next_an;

  function automatic logic [0:6] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1111110;
      4'd1:    decode = 7'b0110000;
      4'd2:    decode = 7'b1101101;
      4'd3:    decode = 7'b1111001;
      4'd4:    decode = 7'b0110011;
      4'd5:    decode = 7'b1011011;
      4'd6:    decode = 7'b1011111;
      4'd7:    decode = 7'b1110000;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1111011;
      default: decode = 7'b0000000;
    endcase
  endfunction

  // upper_zero[i] is set when digit i and every digit above it are zero.
  always_comb begin
    upper_zero = '0;
    upper_zero[NUM_DIGITS-1] = (disp[4*NUM_DIGITS-1 -: 4] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (disp[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_digit = disp[4*int'(idx) +: 4];
    next_an = '0;
    next_an[idx] = 1'b1;
    if (blink_en && phase) begin
      next_segs = 7'b0000000;
    end else if (blank_lz && (idx != '0) && upper_zero[idx]) begin
      next_segs = 7'b0000000;
    end else begin
      next_segs = decode(cur_digit);
    end
  end

  // wrap_d marks the edge where idx wraps; an follows one cycle later, so frame does too.
  always_ff @(posedge clk) begin
    if (reset) begin
      disp      <= '0;
      div_cnt   <= '0;
      idx       <= '0;
      blink_cnt <= '0;
      phase     <= 1'b0;
      wrap_d    <= 1'b0;
      segs      <= '0;
      an        <= '0;
      frame     <= 1'b0;
    end else begin
      if (load) begin
        disp <= digits_in;
      end

      if (div_cnt == DIV_LAST) begin
        div_cnt <= '0;
        idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (blink_cnt == BLINK_LAST) begin
        blink_cnt <= '0;
        phase     <= ~phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      wrap_d <= (div_cnt == DIV_LAST) && (idx == IDX_LAST);
      an     <= next_an;
      segs   <= next_segs;
      frame  <= wrap_d;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-indexed reference model feeds an expected
// queue; a negedge monitor pops and compares every registered output.
module tb_seg7_scan_driver;

  localparam int ND = 3;
  localparam int SD = 4;
  localparam int BD = 16;
  localparam int W  = 7 + ND + 1;

  logic            clk;
  logic            reset;
  logic [4*ND-1:0] digits_in;
  logic            load;
  logic            blank_lz;
  logic            blink_en;
  logic [0:6]      segs;
  logic [ND-1:0]   an;
  logic            frame;

  logic [W-1:0] exp_q[$];
  int           errors = 0;
  int           checks = 0;
  bit           done = 0;
  bit           drain_checked = 0;

  // Reference state: number of non-reset edges since reset, and loaded digits.
  int              n = 0;
  logic [4*ND-1:0] disp_m = '0;
  logic [6:0]      dec_tab [0:15] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                      7'b1111111, 7'b1111011, 7'b0000000, 7'b0000000,
                                      7'b0000000, 7'b0000000, 7'b0000000, 7'b0000000};

  seg7_scan_driver #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .load(load),
    .blank_lz(blank_lz), .blink_en(blink_en), .segs(segs), .an(an), .frame(frame)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // reference model: expected outputs after each rising edge
  always @(posedge clk) begin
    int         cur;
    logic [6:0] seg_e;
    logic [ND-1:0] an_e;
    logic       fr_e;
    logic [4*ND-1:0] above;
    if (reset) begin
      exp_q.push_back('0);
      n = 0;
      disp_m = '0;
    end else begin
      cur   = (n / SD) % ND;
      an_e  = ND'(1) << cur;
      above = disp_m >> (4 * cur);
      if (blink_en && ((n / BD) % 2 == 1)) seg_e = 7'b0000000;
      else if (blank_lz && cur > 0 && above == '0) seg_e = 7'b0000000;
      else seg_e = dec_tab[above[3:0]];
      fr_e = (n > 0) && (n % (ND * SD) == 0);
      exp_q.push_back({seg_e, an_e, fr_e});
      n = n + 1;
      if (load) disp_m = digits_in;
    end
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [W-1:0] got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {segs, an, frame};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL out @%0t: got segs=%b an=%b frame=%b, expected segs=%b an=%b frame=%b",
                 $time, got[W-1 -: 7], got[ND:1], got[0], e[W-1 -: 7], e[ND:1], e[0]);
      end
    end
    if (done && !drain_checked) begin
      drain_checked = 1;
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
      end
    end
  end

  // driver tasks
  task automatic step(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic load_digits(input logic [3:0] d2, input logic [3:0] d1, input logic [3:0] d0);
    digits_in = {d2, d1, d0};
    load = 1'b1;
    step(1);
    load = 1'b0;
  endtask

  // wait on the model's scan position: the next edge is the given cycle of the frame
  task automatic align(input int pos);
    for (int k = 0; k < 4 * ND * SD; k++) begin
      if (n % (ND * SD) == pos) break;
      step(1);
    end
  endtask

  initial begin
    logic [4*ND-1:0] rd;
    reset = 1'b1; digits_in = '0; load = 1'b0; blank_lz = 1'b0; blink_en = 1'b0;
    step(3);
    reset = 1'b0;
    step(30);

    load_digits(4'd2, 4'd1, 4'd8); step(12);
    load_digits(4'd2, 4'd1, 4'd7); step(12);
    load_digits(4'd2, 4'd1, 4'd6); step(12);
    load_digits(4'd2, 4'd1, 4'd0); step(12);

    blank_lz = 1'b1;
    load_digits(4'd0, 4'd0, 4'd9); step(12);
    load_digits(4'd0, 4'd0, 4'd0); step(12);
    load_digits(4'd1, 4'd0, 4'd5); step(12);
    blank_lz = 1'b0;

    load_digits(4'd0, 4'd0, 4'd12); step(12);
    load_digits(4'd3, 4'd4, 4'd5);
    blink_en = 1'b1; step(64);
    blink_en = 1'b0; step(8);

    load_digits(4'd3, 4'd4, 4'd8);
    align(1);
    load_digits(4'd3, 4'd4, 4'd9); step(12);

    blink_en = 1'b1;
    align(SD + 2);
    reset = 1'b1; step(1);
    reset = 1'b0; step(20);
    blink_en = 1'b0;

    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < ND; i++) begin
        rd[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      digits_in = rd;
      load      = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      if ($urandom_range(0, 31) == 0) blink_en = ~blink_en;
      reset     = ($urandom_range(0, 149) == 0);
      step(1);
    end
    reset = 1'b0; load = 1'b0;
    step(2);
    done = 1;
    step(2);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed 7-segment display driver for the timer's digit outputs. It generalises the per-digit BCD decoders to NUM_DIGITS digits that share one segment bus, and adds registered digit loading, digit scanning, leading-zero blanking, blink mode and a frame pulse. It sits between the BCD counter chain and the board's segment and anode pins.

Parameters:
NUM_DIGITS, 3, number of BCD digits scanned (range 1..8).
SCAN_DIV, 4, clock cycles each digit is driven before the scan advances (at least 1).
BLINK_DIV, 16, clock cycles per blink half-period (at least 1).

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
digits_in  input  4*NUM_DIGITS  packed BCD digits; digit i = bits [4i+3:4i]; digit 0 = least significant (sec_ones).
load  input  1  latch digits_in into the display register on this edge.
blank_lz  input  1  enable leading-zero blanking.
blink_en  input  1  enable blinking of the whole display.
segs  output  [0:6]  segments a..g, segs[0]=a, segs[6]=g; 1 = lit.
an  output  NUM_DIGITS  one-hot digit enable; an[i]=1 drives digit i.
frame  output  1  one-cycle pulse when the scan wraps from digit NUM_DIGITS-1 to digit 0.

Behaviour:
- Reset (synchronous, active-high; checked on every rising edge, including mid-scan or mid-blink): display register = 0; div_cnt = 0; idx = 0; blink_cnt = 0; phase = 0; segs = 0; an = 0; frame = 0. Outputs are registered and stay 0 while reset is held.
- Load: when load=1 at an edge, the display register takes digits_in. The scan position and counters are not disturbed. The new value is visible on segs one cycle later, on whichever digit is then being driven. When load=0, the register holds its value.
- Scan: div_cnt counts 0..SCAN_DIV-1. When div_cnt = SCAN_DIV-1, div_cnt returns to 0 and idx advances; idx wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1, idx stays 0.
- Output timing: an and segs are registered from the current idx and register contents, so they lag idx by exactly one cycle. an is one-hot at all times after the first post-reset edge.
- Digit hold time: each digit is driven for exactly SCAN_DIV consecutive cycles. One full frame lasts NUM_DIGITS*SCAN_DIV cycles.
- frame: asserted for one cycle at the same edge where an changes from digit NUM_DIGITS-1 to digit 0. It is never asserted during or immediately after reset. The first wrap after reset produces the first pulse.
- Decode (a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011. Codes 10..15 decode to 0000000 (blank).
- Leading-zero blanking: with blank_lz=1, digit i (i>0) shows 0000000 when digit i and every digit above it are 0. Digit 0 is never blanked by this rule. an still scans normally for blanked digits.
- Blink: blink_cnt counts 0..BLINK_DIV-1. phase toggles when blink_cnt = BLINK_DIV-1. blink_cnt runs whether or not blink_en is set.
  - When blink_en=1 and phase=1, segs = 0000000 for every digit; an keeps scanning.
  - When blink_en deasserts, segs return to normal on the next registered output.
- Priority per digit: reset, then blink blanking, then leading-zero blanking, then decode.

Test Plan:
- Reset and scan (NUM_DIGITS=3, SCAN_DIV=4): hold reset 3 cycles -> segs=0, an=000, frame=0. Release reset -> an follows 001 for 4 cycles, then 010 for 4, then 100 for 4, then 001 again; frame pulses for 1 cycle at that last 100->001 transition; frame pulses then repeat every 12 cycles.
- Load and decode: load digits {min=2, tens=1, ones=8} -> segs while an=001 is 1111111; while an=010 it is 0110000; while an=100 it is 1101101. Update ones to 7, then 6, then 0 -> the ones slot shows 1110000, then 1011111, then 1111110.
- Leading-zero blanking: load {0,0,9} with blank_lz=1 -> the an=100 and an=010 slots show 0000000 and the an=001 slot shows 1111011. Load {0,0,0} -> only digit 0 is lit, showing 1111110. Load {1,0,5} -> the middle 0 shows 1111110 (not blanked).
- Invalid codes and blink: load ones=12 -> that slot shows 0000000. Set blink_en=1 with BLINK_DIV=16 -> all slots show 0000000 for 16 cycles, then normal segments for 16 cycles, alternating, while an keeps scanning.
- Load mid-digit: assert load with ones 8->9 on the 2nd cycle of an=001 -> segs change to 1111011 one cycle later; an timing is unchanged.
- Reset mid-operation: assert reset on the 3rd cycle of an=010 with blink active -> the next cycle shows segs=0 and an=000. After release, scanning restarts at digit 0 with the display register cleared.
